rr_arb_mux: RTL and testbench
=============================

Name: rr_arb_mux

Overview:
- Registered, round-robin arbitrating N:1 multiplexer with per-input valid/ready handshakes and optional packet locking.
- Successor to the combinational select-driven mux. Select is generated internally by a fair arbiter rather than supplied by the caller.
- Used at NoC router output ports and at shared-link merge points where several flit streams contend for one channel.
- One output register stage breaks the timing path.

Parameters:
- N, 4: number of input channels; must be >= 1, any value (non-power-of-2 legal).
- W, 32: width of each data input and the output.
- PKT_LOCK, 1: 1 = hold grant from first beat until the beat with last=1; 0 = re-arbitrate every beat.
- L, localparam = max(1, $clog2(N)): width of the source index.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: synchronous active-low reset; state is reset on a clk edge where rst==0.
- i_data, input, [N-1:0][W-1:0]: per-channel data.
- i_valid, input, [N-1:0]: per-channel beat available.
- i_last, input, [N-1:0]: per-channel end-of-packet marker, qualified by i_valid.
- i_ready, output, [N-1:0]: per-channel accept; at most one bit high per cycle.
- o_data, output, [W-1:0]: registered output data.
- o_valid, output, 1: registered output valid.
- o_last, output, 1: registered end-of-packet marker.
- o_sel, output, [L-1:0]: registered index of the channel that supplied the current output beat.
- o_ready, input, 1: downstream accept.

Behaviour:
- Reset (rst==0 at a clk edge):
  - Outputs: o_valid=0, o_data=0, o_last=0, o_sel=0.
  - Internal: rr pointer ptr=0, lock=0, lock_idx=0.
  - A held output beat or a partial packet is discarded; there is no recovery of in-flight data.
- Load condition: load = !o_valid || o_ready. The output register accepts a new beat only when load=1. This gives full throughput of 1 beat/cycle under continuous o_ready.
- Arbitration, combinational each cycle:
  - If lock=1: the candidate is lock_idx only. Other channels are ignored even if lock_idx has i_valid=0; the output bubbles rather than interleaving.
  - If lock=0: the candidate is the first channel with i_valid=1 scanning ptr, ptr+1, ..., wrapping N-1 -> 0. Wrap uses explicit compare against N-1, not a power-of-2 mask.
  - grant_valid = the candidate has i_valid=1.
- i_ready[g] = load && grant_valid for granted g; all other bits are 0. i_ready may depend combinationally on o_ready. i_ready must not depend on its own channel's i_ready.
- Transfer: on i_valid[g] && i_ready[g], the next edge loads o_data=i_data[g], o_last=i_last[g], o_sel=g, o_valid=1.
- If load=1 and no grant: o_valid goes to 0 next edge. o_data, o_last and o_sel hold their previous values.
- If load=0: the output register holds all values, stable while o_valid && !o_ready.
- Latency: exactly 1 cycle from input handshake to o_valid. There is no combinational path from i_data or i_valid to any o_* signal.
- Pointer and lock update, only on a transfer from channel g:
  - PKT_LOCK=1, i_last[g]=0: lock=1, lock_idx=g, ptr unchanged.
  - PKT_LOCK=1, i_last[g]=1: lock=0, ptr = (g==N-1) ? 0 : g+1.
  - PKT_LOCK=0: ptr advances as above every beat; lock stays 0.
- Single-beat packets (first beat has last=1) never set lock.
- N=1: the arbiter degenerates to a pass-through register; o_sel is constant 0; lock logic still tracks last.
- Simultaneous events:
  - A new input transfer and o_ready in the same cycle is a normal pipelined handoff.
  - Reset in the same cycle as a handshake: reset wins.
- Simulation-only assertions (under SIMULATION):
  - $onehot0(i_ready).
  - o_data, o_last and o_sel stable while o_valid && !o_ready.
  - o_sel < N whenever o_valid.

Test Plan:
- Reset: hold rst=0 for 2 cycles with all i_valid=1 -> o_valid=0, i_ready=0, o_sel=0. Release with o_ready=1, N=4, all i_last=1, all valid -> o_sel sequence 0,1,2,3,0 on consecutive cycles, starting 1 cycle after release.
- Fairness, N=3 (non-power-of-2): channels 0 and 2 always valid, single-beat packets -> o_sel alternates 0,2,0,2. Ptr wraps 2->0 without ever granting index 3.
- Packet lock, PKT_LOCK=1: ch1 sends a 3-beat packet (last on beat 3) while ch0 is continuously valid. ch1 deasserts valid for one cycle mid-packet -> output shows ch1 beats contiguously with a one-cycle o_valid=0 bubble and no ch0 beat. ch0 is granted immediately after ch1's last beat.
- PKT_LOCK=0, same stimulus as the lock test -> beats interleave 1,0,1,0 per round-robin.
- Backpressure: o_ready=0 for 5 cycles with o_valid=1, data=0xDEADBEEF -> o_data, o_sel and o_last are stable and i_ready=0 throughout. When o_ready returns to 1, the next beat appears the following cycle; no beat is lost or duplicated (scoreboard per channel).
- Reset mid-packet: assert rst=0 after beat 2 of a 4-beat ch2 packet -> lock cleared, o_valid=0. After release, ch0 (ptr=0) is granted first.

Source files
------------

// File: rtl/rr_arb_mux.sv
// Registered round-robin N:1 arbitrating mux with per-channel valid/ready and
// optional packet locking. A single output register stage breaks the timing path.

module rr_arb_mux_lane #(
  parameter int W   = 32,
  parameter int L   = 1,
  parameter int IDX = 0
) (
  input  logic         take,
  input  logic [L-1:0] gnt,
  input  logic [W-1:0] data,
  input  logic         last,
  output logic         ready,
  output logic [W-1:0] data_m,
  output logic         last_m
);
  assign ready  = take && (gnt == L'(IDX));
  assign data_m = ready ? data : '0;
  assign last_m = ready && last;
endmodule

module rr_arb_mux #(
  parameter  int N        = 4,
  parameter  int W        = 32,
  parameter  int PKT_LOCK = 1,
  localparam int L        = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0][W-1:0] i_data,
  input  logic [N-1:0]        i_valid,
  input  logic [N-1:0]        i_last,
  output logic [N-1:0]        i_ready,
  output logic [W-1:0]        o_data,
  output logic                o_valid,
  output logic                o_last,
  output logic [L-1:0]        o_sel,
  input  logic                o_ready
);
  logic         load, grant_valid, xfer, lock;
  logic [L-1:0] ptr, lock_idx, gnt, idx;

  logic [N-1:0][W-1:0] data_m;
  logic [N-1:0]        last_m;
  logic [W-1:0]        mux_data;
  logic                mux_last;

  assign load = !o_valid || o_ready;
  // Reset gates i_ready so no upstream beat is consumed on a reset edge.
  assign xfer = rst && load && grant_valid;

  always_comb begin
    gnt         = lock_idx;
    grant_valid = 1'b0;
    idx         = ptr;
    if (lock) begin
      grant_valid = i_valid[lock_idx];
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!grant_valid && i_valid[idx]) begin
          grant_valid = 1'b1;
          gnt         = idx;
        end
        idx = (idx == L'(N-1)) ? '0 : idx + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    rr_arb_mux_lane #(.W(W), .L(L), .IDX(g)) u_lane (
      .take   (xfer),
      .gnt    (gnt),
      .data   (i_data[g]),
      .last   (i_last[g]),
      .ready  (i_ready[g]),
      .data_m (data_m[g]),
      .last_m (last_m[g])
    );
  end

  // i_ready is one-hot, so an OR across lanes is the data mux.
  always_comb begin
    mux_data = '0;
    mux_last = 1'b0;
    for (int g = 0; g < N; g++) begin
      mux_data = mux_data | data_m[g];
      mux_last = mux_last | last_m[g];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_last   <= 1'b0;
      o_sel    <= '0;
      ptr      <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
    end else begin
      if (load) begin
        o_valid <= xfer;
        if (xfer) begin
          o_data <= mux_data;
          o_last <= mux_last;
          o_sel  <= gnt;
        end
      end
      if (xfer) begin
        if (PKT_LOCK != 0 && !mux_last) begin
          lock     <= 1'b1;
          lock_idx <= gnt;
        end else begin
          lock <= 1'b0;
          ptr  <= (gnt == L'(N-1)) ? '0 : gnt + 1'b1;
        end
      end
    end
  end

`ifdef SIMULATION
  always @(posedge clk) begin
    if (rst) begin
      assert ($onehot0(i_ready)) else $error("i_ready not onehot0: %b", i_ready);
      assert (!o_valid || o_sel <= L'(N-1)) else $error("o_sel out of range: %0d", o_sel);
    end
  end

  property p_hold;
    @(posedge clk) disable iff (!rst)
      (o_valid && !o_ready) |=> ($stable(o_data) && $stable(o_last) && $stable(o_sel));
  endproperty
  a_hold: assert property (p_hold);
`endif
endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: three instances (N=4 locked, N=3 locked, N=4 unlocked)
// checked every cycle against a transaction-level reference model.
module tb_rr_arb_mux;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0][W-1:0] id   [3];
  logic [3:0]        iv   [3];
  logic [3:0]        il   [3];
  logic              ordy [3];

  logic [3:0]   rdy_a, rdy_c;
  logic [2:0]   rdy_b;
  logic [W-1:0] od_a, od_b, od_c;
  logic         ov_a, ov_b, ov_c, ol_a, ol_b, ol_c;
  logic [1:0]   os_a, os_b, os_c;

  rr_arb_mux #(.N(4), .W(W), .PKT_LOCK(1)) u_a (
    .clk(clk), .rst(rst), .i_data(id[0]), .i_valid(iv[0]), .i_last(il[0]),
    .i_ready(rdy_a), .o_data(od_a), .o_valid(ov_a), .o_last(ol_a), .o_sel(os_a),
    .o_ready(ordy[0]));

  rr_arb_mux #(.N(3), .W(W), .PKT_LOCK(1)) u_b (
    .clk(clk), .rst(rst), .i_data(id[1][2:0]), .i_valid(iv[1][2:0]), .i_last(il[1][2:0]),
    .i_ready(rdy_b), .o_data(od_b), .o_valid(ov_b), .o_last(ol_b), .o_sel(os_b),
    .o_ready(ordy[1]));

  rr_arb_mux #(.N(4), .W(W), .PKT_LOCK(0)) u_c (
    .clk(clk), .rst(rst), .i_data(id[2]), .i_valid(iv[2]), .i_last(il[2]),
    .i_ready(rdy_c), .o_data(od_c), .o_valid(ov_c), .o_last(ol_c), .o_sel(os_c),
    .o_ready(ordy[2]));

  int tests = 0;
  int fails = 0;

  // Reference model state, one slot per instance.
  int          nn [3] = '{4, 3, 4};
  bit          pl [3] = '{1'b1, 1'b1, 1'b0};
  int          ptr [3], lki [3], ms [3], eg [3];
  bit          lk [3], mv [3], ml [3], egv [3];
  logic [31:0] md [3];
  logic [3:0]  erdy [3];
  int          rem [3][4];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset(int m);
    mv[m] = 0; md[m] = '0; ml[m] = 0; ms[m] = 0;
    ptr[m] = 0; lk[m] = 0; lki[m] = 0;
  endfunction

  // Who should be granted this cycle, and the resulting ready vector.
  function automatic void arb(int m);
    bit load;
    load   = !mv[m] || ordy[m];
    egv[m] = 0;
    eg[m]  = 0;
    if (lk[m]) begin
      eg[m]  = lki[m];
      egv[m] = iv[m][lki[m]];
    end else begin
      for (int k = 0; k < nn[m]; k++) begin
        int c;
        c = (ptr[m] + k) % nn[m];
        if (!egv[m] && iv[m][c]) begin egv[m] = 1; eg[m] = c; end
      end
    end
    erdy[m] = (rst && load && egv[m]) ? 4'(1 << eg[m]) : 4'b0;
  endfunction

  function automatic void advance(int m);
    if (!rst) begin
      model_reset(m);
    end else if (!mv[m] || ordy[m]) begin
      if (egv[m]) begin
        mv[m] = 1; md[m] = id[m][eg[m]]; ml[m] = il[m][eg[m]]; ms[m] = eg[m];
        if (pl[m] && !il[m][eg[m]]) begin
          lk[m] = 1; lki[m] = eg[m];
        end else begin
          lk[m] = 0; ptr[m] = (eg[m] + 1) % nn[m];
        end
      end else begin
        mv[m] = 0;
      end
    end
  endfunction

  task automatic check_model(int m);
    logic [3:0] ar; logic [31:0] ad; logic av, al; logic [1:0] as;
    case (m)
      0:       begin ar = rdy_a;         ad = od_a; av = ov_a; al = ol_a; as = os_a; end
      1:       begin ar = {1'b0, rdy_b}; ad = od_b; av = ov_b; al = ol_b; as = os_b; end
      default: begin ar = rdy_c;         ad = od_c; av = ov_c; al = ol_c; as = os_c; end
    endcase
    chk($sformatf("m%0d_ready", m), 32'(ar), 32'(erdy[m]));
    chk($sformatf("m%0d_valid", m), 32'(av), 32'(mv[m]));
    chk($sformatf("m%0d_data", m), ad, md[m]);
    chk($sformatf("m%0d_last", m), 32'(al), 32'(ml[m]));
    chk($sformatf("m%0d_sel", m), 32'(as), ms[m]);
  endtask

  // Check at the falling edge, then step the model across the rising edge.
  task automatic cycle();
    @(negedge clk);
    for (int m = 0; m < 3; m++) begin arb(m); check_model(m); end
    @(posedge clk);
    for (int m = 0; m < 3; m++) begin
      for (int c = 0; c < 4; c++)
        if (rst && erdy[m][c] && rem[m][c] > 0) rem[m][c]--;
      advance(m);
    end
    #1;
  endtask

  task automatic drive(logic [3:0] v, logic [3:0] l, logic r);
    for (int m = 0; m < 3; m++) begin
      iv[m] = v; il[m] = l; ordy[m] = r;
      for (int c = 0; c < 4; c++) id[m][c] = $urandom;
    end
  endtask

  task automatic set_data(int c, logic [31:0] d);
    for (int m = 0; m < 3; m++) id[m][c] = d;
  endtask

  logic [3:0]  sv [6] = '{4'b0011, 4'b0011, 4'b0011, 4'b0001, 4'b0011, 4'b0001};
  logic [3:0]  sl [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0011, 4'b0001};
  logic [31:0] sd [6] = '{32'hB1, 32'hB1, 32'hB2, 32'h0, 32'hB3, 32'h0};
  bit          xv [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  int          xs [6] = '{0, 1, 1, 0, 1, 0};

  initial begin
    logic [31:0] save;
    int exp_sel;

    rst = 1'b0;
    drive(4'hF, 4'hF, 1'b1);
    for (int m = 0; m < 3; m++) for (int c = 0; c < 4; c++) rem[m][c] = 0;
    @(posedge clk); #1;
    for (int m = 0; m < 3; m++) model_reset(m);

    // Reset held with every channel valid
    for (int k = 0; k < 2; k++) begin
      cycle();
      chk("rst_valid", 32'(ov_a), 0);
      chk("rst_ready", 32'(rdy_a), 0);
      chk("rst_sel", 32'(os_a), 0);
    end
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("rr_sel", 32'(os_a), k % 4);
      chk("rr_valid", 32'(ov_a), 1);
    end

    // Fairness on N=3 with channels 0 and 2 contending
    drive(4'b0101, 4'hF, 1'b1);
    exp_sel = 2;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("fair_sel", 32'(os_b), exp_sel);
      exp_sel = (exp_sel == 2) ? 0 : 2;
      drive(4'b0101, 4'hF, 1'b1);
    end

    // Packet lock: ch1 3-beat packet with a mid-packet gap, ch0 always valid
    rst = 1'b0; drive(4'h0, 4'h0, 1'b1); cycle();
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive(sv[k], sl[k], 1'b1);
      set_data(1, sd[k]);
      cycle();
      chk("lock_valid", 32'(ov_a), 32'(xv[k]));
      if (xv[k]) chk("lock_sel", 32'(os_a), xs[k]);
      if (k == 1 || k == 2) chk("lock_data", od_a, sd[k]);
      if (k == 4) chk("lock_last", 32'(ol_a), 1);
    end

    // Backpressure holding a ch3 beat
    rst = 1'b0; drive(4'h0, 4'h0, 1'b1); cycle();
    rst = 1'b1;
    drive(4'b1000, 4'hF, 1'b1);
    set_data(3, 32'hDEADBEEF);
    cycle();
    chk("bp_load", od_a, 32'hDEADBEEF);
    for (int k = 0; k < 5; k++) begin
      drive(4'hF, 4'hF, 1'b0);
      cycle();
      chk("bp_data", od_a, 32'hDEADBEEF);
      chk("bp_sel", 32'(os_a), 3);
      chk("bp_last", 32'(ol_a), 1);
      chk("bp_ready", 32'(rdy_a), 0);
    end
    drive(4'hF, 4'hF, 1'b1);
    save = id[0][0];
    cycle();
    chk("bp_resume_sel", 32'(os_a), 0);
    chk("bp_resume_data", od_a, save);

    // Reset in the middle of a ch2 packet
    rst = 1'b0; drive(4'h0, 4'h0, 1'b1); cycle();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(4'b0100, 4'h0, 1'b1);
      cycle();
      chk("mid_sel", 32'(os_a), 2);
    end
    rst = 1'b0; drive(4'b0101, 4'h0, 1'b1); cycle();
    chk("mid_rst_valid", 32'(ov_a), 0);
    rst = 1'b1; drive(4'b0101, 4'h0, 1'b1); cycle();
    chk("mid_after_sel", 32'(os_a), 0);
    chk("mid_after_valid", 32'(ov_a), 1);

    // Randomized packet traffic with random backpressure and rare resets
    for (int m = 0; m < 3; m++) for (int c = 0; c < 4; c++) rem[m][c] = 0;
    for (int t = 0; t < 3000; t++) begin
      rst = ($urandom_range(0, 99) != 0);
      for (int m = 0; m < 3; m++) begin
        ordy[m] = ($urandom_range(0, 3) != 0);
        for (int c = 0; c < 4; c++) begin
          if (rem[m][c] == 0 && $urandom_range(0, 2) == 0) rem[m][c] = $urandom_range(1, 4);
          iv[m][c] = (rem[m][c] > 0) && ($urandom_range(0, 3) != 0);
          il[m][c] = (rem[m][c] == 1);
          id[m][c] = $urandom;
        end
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
